// File: rtl/spi_pkg.sv
// Shared SPI constants and types, used by the master and by any slave model.
package spi_pkg;

    localparam int   SPI_DATA_W = 8;
    localparam int   SPI_CNT_W  = $clog2(SPI_DATA_W);
    localparam logic CS_ACTIVE  = 1'b0;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

endpackage

// File: rtl/spi_master.sv
// Byte-wide, LSB-first, full-duplex SPI master with per-slave active-low
// chip selects. Control and MISO sampling run on the SCLK negedge; MOSI is
// driven on the SCLK posedge.
module spi_master
    import spi_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  SCLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_W-1:0]      slaveSelect,
    input  logic [SPI_DATA_W-1:0] masterDataToSend,
    output logic [SPI_DATA_W-1:0] masterDataReceived,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_SLAVES-1:0] CS,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_DATA_W - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    launch;
    logic                    finish;
    logic                    sel_ok;
    logic                    cs_sel_low;
    logic [NUM_SLAVES-1:0]   cs_launch;
    logic [SEL_W-1:0]        sel_reg;
    logic [SPI_DATA_W-1:0]   tx_reg;
    logic [SPI_DATA_W-1:0]   rx_reg;
    logic [SPI_CNT_W-1:0]    rx_cnt;
    logic [SPI_CNT_W-1:0]    tx_cnt;

    // Out-of-range slave indices are rejected rather than aliased onto a real CS
    assign sel_ok = (32'(slaveSelect) < 32'(NUM_SLAVES));

    // Chip-select pattern for a new request, and whether the latched slave's CS is active
    always_comb begin
        cs_launch  = '1;
        cs_sel_low = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (slaveSelect == SEL_W'(i)) begin
                cs_launch[i] = CS_ACTIVE;
            end
            if (sel_reg == SEL_W'(i)) begin
                cs_sel_low = (CS[i] == CS_ACTIVE);
            end
        end
    end

    // State register
    always_ff @(negedge SCLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start && sel_ok)     state_nxt = XFER;
            XFER: if (rx_cnt == LAST_BIT)  state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Per-state control strobes for the datapath
    always_comb begin
        launch = 1'b0;
        finish = 1'b0;
        unique case (state)
            IDLE:    launch = start && sel_ok;
            XFER:    finish = (rx_cnt == LAST_BIT);
            default: ;
        endcase
    end

    // Negedge datapath: framing, handshake and MISO capture
    always_ff @(negedge SCLK or posedge reset) begin
        if (reset) begin
            CS                 <= {NUM_SLAVES{~CS_ACTIVE}};
            busy               <= 1'b0;
            done               <= 1'b0;
            masterDataReceived <= '0;
            sel_reg            <= '0;
            tx_reg             <= '0;
            rx_reg             <= '0;
            rx_cnt             <= '0;
        end else begin
            if (state == IDLE) begin
                done <= 1'b0;
                if (launch) begin
                    tx_reg  <= masterDataToSend;
                    sel_reg <= slaveSelect;
                    CS      <= cs_launch;
                    busy    <= 1'b1;
                    rx_cnt  <= '0;
                end
            end else begin
                rx_reg[rx_cnt] <= MISO;
                rx_cnt         <= rx_cnt + SPI_CNT_W'(1);
                if (finish) begin
                    // Final bit goes straight to the output; rx_reg[7] is not yet updated here
                    CS                 <= {NUM_SLAVES{~CS_ACTIVE}};
                    busy               <= 1'b0;
                    done               <= 1'b1;
                    masterDataReceived <= {MISO, rx_reg[SPI_DATA_W-2:0]};
                end
            end
        end
    end

    // Posedge MOSI driver, shifting tx_reg out LSB first while the slave is selected
    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            MOSI   <= 1'b0;
            tx_cnt <= '0;
        end else if (cs_sel_low) begin
            MOSI   <= tx_reg[tx_cnt];
            tx_cnt <= tx_cnt + SPI_CNT_W'(1);
        end else begin
            MOSI   <= 1'b0;
            tx_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural SPI slaves on the shared bus, directed
// scenarios plus randomized transfers checked against byte-level expectations.
module tb_spi_master;
    import spi_pkg::*;

    localparam int NS = 4;
    localparam int SW = 3;

    logic          SCLK = 1'b0;
    logic          reset = 1'b0;
    logic          start;
    logic [SW-1:0] slaveSelect;
    logic [7:0]    masterDataToSend;
    logic [7:0]    masterDataReceived;
    logic          busy;
    logic          done;
    logic [NS-1:0] CS;
    logic          MOSI;
    logic          MISO = 1'bz;

    int n_cmp = 0;
    int n_mis = 0;
    int multi_low = 0;

    logic [7:0] slave_tx [NS];
    logic [7:0] slave_rx [NS];
    int         scnt = 0;

    always #5 SCLK = ~SCLK;

    spi_master #(.NUM_SLAVES(NS), .SEL_W(SW)) dut (
        .SCLK               (SCLK),
        .reset              (reset),
        .start              (start),
        .slaveSelect        (slaveSelect),
        .masterDataToSend   (masterDataToSend),
        .masterDataReceived (masterDataReceived),
        .busy               (busy),
        .done               (done),
        .CS                 (CS),
        .MOSI               (MOSI),
        .MISO               (MISO)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int active_slave(input logic [NS-1:0] cs);
        int idx = -1;
        for (int i = 0; i < NS; i++) begin
            if (cs[i] === CS_ACTIVE) idx = i;
        end
        return idx;
    endfunction

    // Slave side, transmit: drive MISO LSB first on posedges while selected
    always @(posedge SCLK) begin
        int j;
        j = active_slave(CS);
        if (j >= 0) begin
            MISO <= slave_tx[j][scnt];
            scnt <= (scnt + 1) % 8;
        end else begin
            MISO <= 1'bz;
            scnt <= 0;
        end
    end

    // Slave side, receive: sample MOSI on negedges while selected (CS seen before the edge)
    always @(negedge SCLK) begin
        int k;
        k = active_slave(CS);
        if ($countones(~CS) > 1) multi_low++;
        if (k >= 0) begin
            slave_rx[k] <= {MOSI, slave_rx[k][7:1]};
        end else begin
            for (int i = 0; i < NS; i++) slave_rx[i] <= 8'h00;
        end
    end

    // One transfer from start request to n8; optional second start pulse at p(glitch_k),
    // optional hold of start for an immediate follow-on transfer.
    task automatic xfer(input logic [SW-1:0] sel, input logic [7:0] mdata,
                        input logic [7:0] sdata, input int glitch_k, input bit hold);
        logic [NS-1:0] exp_cs;
        int            bad;
        exp_cs = ~(NS'(1) << sel);
        slave_tx[int'(sel)] = sdata;
        @(posedge SCLK);
        start            = 1'b1;
        slaveSelect      = sel;
        masterDataToSend = mdata;
        @(negedge SCLK); #1;
        check_val("n0_cs", 32'(CS), 32'(exp_cs));
        check_val("n0_busy", 32'(busy), 32'd1);
        check_val("n0_done", 32'(done), 32'd0);
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge SCLK);
            if (k == 1 && !hold) start = 1'b0;
            if (glitch_k != 0 && k == glitch_k) begin
                start            = 1'b1;
                masterDataToSend = 8'h55;
            end
            if (glitch_k != 0 && k == glitch_k + 1) start = 1'b0;
            @(negedge SCLK); #1;
            if (k < 8 && (CS !== exp_cs || busy !== 1'b1 || done !== 1'b0)) bad++;
        end
        check_val("cs_busy_window", 32'(bad), 32'd0);
        check_val("n8_done", 32'(done), 32'd1);
        check_val("n8_busy", 32'(busy), 32'd0);
        check_val("n8_cs", 32'(CS), 32'hF);
        check_val("master_rx", 32'(masterDataReceived), 32'(sdata));
        check_val("slave_rx", 32'(slave_rx[int'(sel)]), 32'(mdata));
        if (!hold) begin
            @(posedge SCLK);
            @(negedge SCLK); #1;
            check_val("n9_done", 32'(done), 32'd0);
            check_val("n9_cs", 32'(CS), 32'hF);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         bad;
        logic [2:0] bad_sel [3];
        bit         hold;
        start            = 1'b0;
        slaveSelect      = '0;
        masterDataToSend = 8'h00;
        for (int i = 0; i < NS; i++) slave_tx[i] = 8'h00;
        bad_sel[0] = 3'd4;
        bad_sel[1] = 3'd5;
        bad_sel[2] = 3'd7;

        #1 reset = 1'b1;
        #2;
        check_val("rst_cs", 32'(CS), 32'hF);
        check_val("rst_mosi", 32'(MOSI), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_rx", 32'(masterDataReceived), 32'd0);
        @(posedge SCLK);
        reset = 1'b0;

        // Loopback, selected slave, back-to-back, ignored mid-transfer start
        xfer(3'd0, 8'hA5, 8'h3C, 0, 1'b0);
        xfer(3'd2, 8'h81, 8'h7E, 0, 1'b0);
        xfer(3'd1, 8'h0F, 8'h11, 0, 1'b1);
        xfer(3'd1, 8'hF0, 8'h22, 0, 1'b0);
        xfer(3'd3, 8'h12, 8'h99, 3, 1'b0);

        // Out-of-range slave indices never assert a chip select
        for (int s = 0; s < 3; s++) begin
            @(posedge SCLK);
            start            = 1'b1;
            slaveSelect      = bad_sel[s];
            masterDataToSend = 8'hAA;
            bad = 0;
            repeat (4) begin
                @(negedge SCLK); #1;
                if (CS !== 4'hF || busy !== 1'b0 || done !== 1'b0) bad++;
            end
            @(posedge SCLK);
            start = 1'b0;
            check_val("bad_sel_idle", 32'(bad), 32'd0);
        end

        // Reset at n4 of a 0xFF transfer
        slave_tx[1] = 8'h6B;
        @(posedge SCLK);
        start            = 1'b1;
        slaveSelect      = 3'd1;
        masterDataToSend = 8'hFF;
        @(negedge SCLK);
        @(posedge SCLK);
        start = 1'b0;
        repeat (4) @(negedge SCLK);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_cs", 32'(CS), 32'hF);
        check_val("midrst_mosi", 32'(MOSI), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_rx", 32'(masterDataReceived), 32'd0);
        @(posedge SCLK);
        reset = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge SCLK); #1;
            if (done !== 1'b0 || busy !== 1'b0 || CS !== 4'hF) bad++;
        end
        check_val("midrst_no_done", 32'(bad), 32'd0);

        // Randomized transfers, some chained back-to-back
        for (int t = 0; t < 24; t++) begin
            hold = (t != 23) && ($urandom_range(0, 3) == 0);
            xfer(3'($urandom_range(0, NS - 1)), 8'($urandom), 8'($urandom), 0, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(posedge SCLK);
        end

        check_val("one_cs_low", 32'(multi_low), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
